// File: rtl/accel_avg_filter.sv
// Three-axis moving-average filter for accelerometer samples.
// Each axis keeps a circular window of 2^DEPTH_LOG2 samples and a running sum; outputs are the floored mean.
module accel_avg_filter #(
    parameter int WIDTH      = 10,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic signed [WIDTH-1:0] i_x_data,
    input  logic signed [WIDTH-1:0] i_y_data,
    input  logic signed [WIDTH-1:0] i_z_data,
    input  logic                    i_data_valid,
    input  logic                    i_clear,
    output logic signed [WIDTH-1:0] o_x_data,
    output logic signed [WIDTH-1:0] o_y_data,
    output logic signed [WIDTH-1:0] o_z_data,
    output logic                    o_data_valid,
    output logic                    o_primed
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SUM_W = WIDTH + DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int AXES  = 3;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      w_accept;
    logic                      w_last_fill;
    logic                      w_emit;
    logic                      w_primed;

    logic signed [WIDTH-1:0]   w_in [AXES];
    logic signed [WIDTH-1:0]   r_buf [AXES][DEPTH];
    logic signed [SUM_W-1:0]   r_sum_p0 [AXES];
    logic [DEPTH_LOG2-1:0]     r_wr_ptr;
    logic [CNT_W-1:0]          r_count;
    logic                      r_vld_p0;

    // Floor division by the window size: arithmetic shift rounds toward -inf,
    // and the mean of WIDTH-bit samples always fits back into WIDTH bits.
    function automatic logic signed [WIDTH-1:0] f_mean(input logic signed [SUM_W-1:0] s);
        return WIDTH'(s >>> DEPTH_LOG2);
    endfunction

    assign w_in[0]     = i_x_data;
    assign w_in[1]     = i_y_data;
    assign w_in[2]     = i_z_data;
    assign w_accept    = i_data_valid & ~i_clear;
    assign w_last_fill = (r_count == CNT_W'(DEPTH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_clear) begin
            w_next_state = S_FILL;
        end else if (w_accept && (r_state == S_FILL) && w_last_fill) begin
            w_next_state = S_RUN;
        end
    end

    always_comb begin
        w_primed = (r_state == S_RUN);
        w_emit   = w_accept && ((r_state == S_RUN) || w_last_fill);
    end

    assign o_primed = w_primed;

    // Stage p0: window update and running sums
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int a = 0; a < AXES; a++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    r_buf[a][d] <= '0;
                end
                r_sum_p0[a] <= '0;
            end
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_vld_p0 <= 1'b0;
        end else if (i_clear) begin
            for (int a = 0; a < AXES; a++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    r_buf[a][d] <= '0;
                end
                r_sum_p0[a] <= '0;
            end
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= w_emit;
            if (w_accept) begin
                for (int a = 0; a < AXES; a++) begin
                    r_sum_p0[a]          <= r_sum_p0[a] + SUM_W'(w_in[a])
                                            - SUM_W'(r_buf[a][r_wr_ptr]);
                    r_buf[a][r_wr_ptr]   <= w_in[a];
                end
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_state == S_FILL) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    // Stage p1: registered means; a pulse pending from p0 still issues on a clear edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_x_data     <= '0;
            o_y_data     <= '0;
            o_z_data     <= '0;
            o_data_valid <= 1'b0;
        end else begin
            o_data_valid <= r_vld_p0;
            if (r_vld_p0) begin
                o_x_data <= f_mean(r_sum_p0[0]);
                o_y_data <= f_mean(r_sum_p0[1]);
                o_z_data <= f_mean(r_sum_p0[2]);
            end
        end
    end

endmodule

// File: tb/tb_accel_avg_filter.sv
// Directed testbench for accel_avg_filter (WIDTH=10, DEPTH=8) with a window-sum reference model.
module tb_accel_avg_filter;

    localparam int W = 10;
    localparam int D = 8;

    logic                i_clk;
    logic                i_rst_n;
    logic signed [W-1:0] i_x_data, i_y_data, i_z_data;
    logic                i_data_valid;
    logic                i_clear;
    logic signed [W-1:0] o_x_data, o_y_data, o_z_data;
    logic                o_data_valid;
    logic                o_primed;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulses = 0;
    int q_x[$], q_y[$], q_z[$];
    int exp_x[$], exp_y[$], exp_z[$];
    int m_buf[3][D];
    int m_ptr = 0;
    int m_cnt = 0;

    accel_avg_filter #(.WIDTH(W), .DEPTH_LOG2(3)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_x_data     (i_x_data),
        .i_y_data     (i_y_data),
        .i_z_data     (i_z_data),
        .i_data_valid (i_data_valid),
        .i_clear      (i_clear),
        .o_x_data     (o_x_data),
        .o_y_data     (o_y_data),
        .o_z_data     (o_z_data),
        .o_data_valid (o_data_valid),
        .o_primed     (o_primed)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        #1;
        if (o_data_valid) begin
            n_pulses++;
            q_x.push_back(int'(o_x_data));
            q_y.push_back(int'(o_y_data));
            q_z.push_back(int'(o_z_data));
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fdiv8(input int s);
        if (s >= 0) return s / D;
        return -((-s + D - 1) / D);
    endfunction

    task automatic model_clear();
        for (int a = 0; a < 3; a++)
            for (int d = 0; d < D; d++) m_buf[a][d] = 0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic model_push(input int x, input int y, input int z);
        int s[3];
        m_buf[0][m_ptr] = x;
        m_buf[1][m_ptr] = y;
        m_buf[2][m_ptr] = z;
        m_ptr = (m_ptr + 1) % D;
        if (m_cnt < D) m_cnt++;
        if (m_cnt == D) begin
            for (int a = 0; a < 3; a++) begin
                s[a] = 0;
                for (int d = 0; d < D; d++) s[a] += m_buf[a][d];
            end
            exp_x.push_back(fdiv8(s[0]));
            exp_y.push_back(fdiv8(s[1]));
            exp_z.push_back(fdiv8(s[2]));
        end
    endtask

    task automatic drive(input logic v, input logic c, input int x, input int y, input int z);
        @(negedge i_clk);
        i_data_valid = v;
        i_clear      = c;
        i_x_data     = W'(x);
        i_y_data     = W'(y);
        i_z_data     = W'(z);
        if (c) model_clear();
        else if (v) model_push(x, y, z);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic settle();
        idle();
        idle();
        idle();
    endtask

    task automatic cmp_queues(input string tag);
        check($sformatf("%s_cnt", tag), q_x.size(), exp_x.size());
        for (int i = 0; i < q_x.size() && i < exp_x.size(); i++) begin
            check($sformatf("%s_x%0d", tag, i), q_x[i], exp_x[i]);
            check($sformatf("%s_y%0d", tag, i), q_y[i], exp_y[i]);
            check($sformatf("%s_z%0d", tag, i), q_z[i], exp_z[i]);
        end
        q_x.delete(); q_y.delete(); q_z.delete();
        exp_x.delete(); exp_y.delete(); exp_z.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_x"}, int'(o_x_data), 0);
        check({tag, "_y"}, int'(o_y_data), 0);
        check({tag, "_z"}, int'(o_z_data), 0);
        check({tag, "_vld"}, int'(o_data_valid), 0);
        check({tag, "_primed"}, int'(o_primed), 0);
    endtask

    initial begin
        int p0;
        int hx, hy, hz;

        i_rst_n = 1'b0;
        i_data_valid = 1'b0;
        i_clear = 1'b0;
        i_x_data = '0;
        i_y_data = '0;
        i_z_data = '0;
        model_clear();
        #2;
        check_zero_outputs("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Fill: no pulse for samples 1-7, first pulse two edges after the 8th
        p0 = n_pulses;
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 16, -16, 255);
        idle();
        idle();
        check("fill_nopulse", n_pulses - p0, 0);
        check("fill_primed7", int'(o_primed), 0);
        drive(1'b1, 1'b0, 16, -16, 255);
        idle();
        check("fill_primed8", int'(o_primed), 1);
        check("fill_lat1_vld", int'(o_data_valid), 0);
        idle();
        check("fill_lat2_vld", int'(o_data_valid), 1);
        check("fill_x", int'(o_x_data), 16);
        check("fill_y", int'(o_y_data), -16);
        check("fill_z", int'(o_z_data), 255);
        idle();
        check("fill_vld_drop", int'(o_data_valid), 0);
        check("fill_hold_x", int'(o_x_data), 16);
        settle();
        cmp_queues("fill");

        // Floor rounding and pointer wrap
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, -1, -1, -1);
        settle();
        cmp_queues("neg1");
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 0, 0, 0);
        settle();
        check("round_first", q_x[0], -1);
        check("round_k7", q_x[6], -1);
        check("round_k8", q_x[7], 0);
        check("round_k9", q_x[8], 0);
        cmp_queues("round");

        // Extremes: full-scale negative then full-scale positive
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, -512, 511, 0);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 511, -512, 0);
        settle();
        check("ext_x_half", q_x[3], -256);
        check("ext_x_min", q_x[7], -512);
        check("ext_y_max", q_y[7], 511);
        check("ext_x_rise1", q_x[8], -385);
        check("ext_x_max", q_x[15], 511);
        check("ext_y_min", q_y[15], -512);
        for (int i = 8; i < 16; i++) check("ext_mono", int'(q_x[i] > q_x[i-1]), 1);
        cmp_queues("ext");

        // Back-to-back strobes
        p0 = n_pulses;
        for (int i = 0; i < 20; i++)
            drive(1'b1, 1'b0, (i * 37) % 1024 - 512, 511 - (i * 53) % 1024, (i * 91) % 1000 - 500);
        settle();
        check("b2b_pulses", n_pulses - p0, 20);
        cmp_queues("b2b");

        // Clear coincident with a sample: pending pulse still issues, sample dropped
        drive(1'b1, 1'b0, 100, -100, 300);
        hx = exp_x[$];
        hy = exp_y[$];
        hz = exp_z[$];
        drive(1'b1, 1'b1, 77, 77, 77);
        idle();
        check("clr_primed", int'(o_primed), 0);
        check("clr_pending_vld", int'(o_data_valid), 1);
        check("clr_pending_x", int'(o_x_data), hx);
        idle();
        check("clr_vld_off", int'(o_data_valid), 0);
        check("clr_hold_y", int'(o_y_data), hy);
        check("clr_hold_z", int'(o_z_data), hz);
        settle();
        cmp_queues("clr_pend");
        p0 = n_pulses;
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 40, -40, 8);
        settle();
        check("clr_refill_nopulse", n_pulses - p0, 0);
        check("clr_refill_hold", int'(o_x_data), hx);
        drive(1'b1, 1'b0, 40, -40, 8);
        settle();
        check("clr_refill_pulse", n_pulses - p0, 1);
        check("clr_refill_x", int'(o_x_data), 40);
        check("clr_refill_y", int'(o_y_data), -40);
        check("clr_refill_z", int'(o_z_data), 8);
        cmp_queues("clr_refill");

        // Async reset mid-FILL
        drive(1'b0, 1'b1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 200, 200, 200);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        i_data_valid = 1'b0;
        model_clear();
        #1;
        check_zero_outputs("rst_fill");
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8, 16, -24);
        settle();
        check("rst_fill_x", int'(o_x_data), 8);
        cmp_queues("rst_fill");

        // Async reset mid-RUN with a pulse pending
        drive(1'b1, 1'b0, 100, 100, 100);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        i_data_valid = 1'b0;
        model_clear();
        q_x.delete(); q_y.delete(); q_z.delete();
        exp_x.delete(); exp_y.delete(); exp_z.delete();
        p0 = n_pulses;
        #1;
        check_zero_outputs("rst_run");
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        check("rst_run_nostray", n_pulses - p0, 0);
        check("rst_run_primed", int'(o_primed), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
